// File: rtl/ahb_sram_ws.sv
// ahb_sram_ws: AHB-Lite SRAM slave with wait states, two-cycle ERROR and read-after-write forwarding.
// Define AHB_SRAM_WS_ALIGN_CHK_EN to turn misaligned transfers into ERROR instead of forcing alignment.
module ahb_sram_ws #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * NB);
  localparam logic [3:0] CNT0 = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic pend, accept, legal, misal, commit;
  logic [IW-1:0] pidx, aidx;
  logic [NB-1:0] pstrb, strb;
  logic [31:0] off;
  logic [LB-1:0] lo, szmask;
  logic [DATA_W-1:0] rd_word;
  logic unused;
  assign unused = ^{HBURST, HPROT};
  assign accept = HSEL & HREADY & HTRANS[1];
  assign off = HADDR - BASE_ADDR;
  assign aidx = off[LB +: IW];
  assign lo = HADDR[LB-1:0];
  assign szmask = LB'((32'd1 << HSIZE) - 32'd1);
  assign misal = |(lo & szmask);
`ifdef AHB_SRAM_WS_ALIGN_CHK_EN
  assign legal = (off < SPAN) && (HSIZE <= 3'(LB)) && !misal;
`else
  assign legal = (off < SPAN) && (HSIZE <= 3'(LB));
`endif
  // lanes start at the address rounded down to the transfer size
  assign strb = NB'(((64'd1 << (32'd1 << HSIZE)) - 64'd1) << (lo & ~szmask));
  assign commit = pend & HREADYOUT;
  assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
  assign HRESP = (state == S_ERR1) || (state == S_ERR2);
  always_comb begin
    state_n = state;
    if (accept) state_n = !legal ? S_ERR1 : (WAIT_STATES == 0 ? S_IDLE : S_WAIT);
    else if (state == S_WAIT) state_n = cnt == 4'd0 ? S_IDLE : S_WAIT;
    else if (state == S_ERR1) state_n = S_ERR2;
    else if (state == S_ERR2) state_n = S_IDLE;
  end
  // a read landing on the edge that commits a write to the same word sees the new bytes
  always_comb begin
    rd_word = mem[aidx];
    for (int b = 0; b < NB; b++)
      if (commit && pidx == aidx && pstrb[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      pend   <= 1'b0;
      pidx   <= '0;
      pstrb  <= '0;
      HRDATA <= '0;
    end else begin
      state <= state_n;
      cnt   <= (accept && legal) ? CNT0 : (state == S_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      pend  <= accept ? (legal & HWRITE) : (pend & ~commit);
      if (accept) begin
        pidx   <= aidx;
        pstrb  <= strb;
        HRDATA <= !legal ? '0 : HWRITE ? HRDATA : rd_word;
      end
    end
  end
  always_ff @(posedge HCLK)
    if (commit)
      for (int b = 0; b < NB; b++)
        if (pstrb[b]) mem[pidx][8*b +: 8] <= HWDATA[8*b +: 8];
endmodule

// File: tb/tb_ahb_sram_ws.sv
// tb_ahb_sram_ws: random AHB master with a byte-array reference model and a queue-based response monitor.
module tb_ahb_sram_ws;
  localparam int WS = 2;
  localparam logic [31:0] BASE = 32'h0010_0000;
  logic HCLK = 0, HRESET = 0, HSEL = 0, HWRITE = 0, HREADYOUT, HRESP;
  logic [31:0] HADDR = 0, HWDATA = 0, HRDATA;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 0, HBURST = 0;
  logic [3:0] HPROT = 0;
  ahb_sram_ws #(.DATA_W(32), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADYOUT), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP));
  always #5 HCLK = ~HCLK;
  typedef struct {bit err; bit rd; logic [31:0] data;} exp_t;
  exp_t q[$];
  logic [7:0] mm [1024];
  int n_cmp = 0, n_err = 0, lowcnt = 0;
  bit mon_en = 0, resp_bad = 0;
  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  function automatic exp_t model(logic [31:0] a, bit w, logic [2:0] sz, logic [31:0] d);
    exp_t e;
    logic [31:0] off = a - BASE;
    int n = 1 << sz;
    int bb;
    e.rd = !w;
    e.data = 0;
    e.err = (off >= 32'd1024) || (sz > 3'd2);
`ifdef AHB_SRAM_WS_ALIGN_CHK_EN
    if (a % n != 0) e.err = 1;
`endif
    if (!e.err) begin
      bb = int'(off) / n * n;
      if (w) for (int i = 0; i < n; i++) mm[bb+i] = d[8*((bb+i)%4) +: 8];
      else for (int i = 0; i < 4; i++) e.data[8*i +: 8] = mm[int'(off)/4*4+i];
    end
    return e;
  endfunction
  always @(negedge HCLK) begin
    exp_t e;
    if (mon_en && q.size() > 0) begin
      if (!HREADYOUT) begin
        if (HRESP !== q[0].err) resp_bad = 1;
        lowcnt++;
      end else begin
        e = q.pop_front();
        check("wait_cycles", 32'(lowcnt), e.err ? 32'd1 : 32'(WS));
        check("hresp", 32'(HRESP), 32'(e.err));
        check("hresp_while_low", 32'(resp_bad), 32'd0);
        if (e.rd || e.err) check("hrdata", HRDATA, e.err ? 32'd0 : e.data);
        lowcnt = 0;
        resp_bad = 0;
      end
    end
  end
  task automatic issue(logic [31:0] a, bit w, logic [2:0] sz, logic [31:0] d);
    int g = 0;
    HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
    while (HREADYOUT !== 1'b1 && g < 50) begin
      @(negedge HCLK);
      g++;
    end
    if (g == 50) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: HREADYOUT stayed 0 for addr %h, want 1", a);
    end
    @(posedge HCLK); #1;
    q.push_back(model(a, w, sz, d));
    HWDATA = w ? d : $urandom;
    HSEL = 0; HTRANS = 2'b00;
    @(negedge HCLK);
  endtask
  task automatic idle();
    HSEL = 1'($urandom);
    HTRANS = HSEL ? {1'b0, 1'($urandom)} : 2'($urandom);
    HADDR = BASE + $urandom_range(0, 1023); HWRITE = 1; HSIZE = 2;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 0;
  endtask
  initial begin
    #2 HRESET = 1;
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESET = 0;
    mon_en = 1;
    for (int i = 0; i < 256; i++) issue(BASE + 32'(4*i), 1, 2, $urandom);
    issue(BASE + 32'h10, 1, 2, 32'hDEADBEEF);
    issue(BASE + 32'h10, 0, 2, 0);
    issue(BASE, 1, 2, 32'h11223344);
    issue(BASE + 2, 1, 0, 32'h00AA0000);
    issue(BASE, 0, 2, 0);
    issue(BASE + 32'h400, 1, 2, 32'hCAFEF00D);
    issue(BASE + 32'h400, 0, 2, 0);
    issue(BASE, 1, 3, 32'h55555555);
    issue(BASE, 0, 2, 0);
    issue(BASE + 1, 1, 1, 32'hBBCCDDEE);
    issue(BASE, 0, 2, 0);
    issue(BASE + 8, 0, 2, 0);
    repeat (6) @(negedge HCLK);
    mon_en = 0;
    HSEL = 1; HTRANS = 2'b10; HADDR = BASE + 8; HWRITE = 1; HSIZE = 2;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 0; HWDATA = 32'hFFFF_FFFF;
    @(negedge HCLK);
    check("mid_wait_low", 32'(HREADYOUT), 32'd0);
    HRESET = 1;
    #1;
    check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(HRESP), 32'd0);
    check("midrst_hrdata", HRDATA, 32'd0);
    @(negedge HCLK);
    HRESET = 0;
    @(negedge HCLK);
    mon_en = 1;
    issue(BASE + 8, 0, 2, 0);
    begin
      logic [31:0] la = BASE;
      for (int i = 0; i < 400; i++) begin
        int r;
        logic [31:0] a;
        logic [2:0] sz;
        r = $urandom_range(0, 99);
        sz = 3'($urandom_range(0, 2));
        if (r < 5) sz = 3'd3;
        a = BASE + $urandom_range(0, 1023);
        if (r >= 5 && r < 10) a = BASE + 32'h400 + $urandom_range(0, 255);
        else if (r >= 10 && r < 13) a = BASE - 32'($urandom_range(1, 16));
        else if (r >= 40 && r < 70) a = la;
        issue(a, 1'($urandom), sz, $urandom);
        la = a;
        if (r >= 88) idle();
      end
    end
    repeat (8) @(negedge HCLK);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
